// File: rtl/addac_n_if.sv
// Handshake/result bundle for the addac_n accumulator.
//   a, sel0, sel1, in_valid              : operand, op select and strobe (master -> slave)
//   s, cout, ovf, ovf_sticky, zero,
//   out_valid, op_cnt                    : accumulator state and status (slave -> master)
// master: the requester driving operations; slave: the accumulator.
interface addac_n_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
);
    logic [WIDTH-1:0] a;
    logic             sel0;
    logic             sel1;
    logic             in_valid;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             ovf_sticky;
    logic             zero;
    logic             out_valid;
    logic [CNT_W-1:0] op_cnt;

    modport master (
        output a, sel0, sel1, in_valid,
        input  s, cout, ovf, ovf_sticky, zero, out_valid, op_cnt
    );

    modport slave (
        input  a, sel0, sel1, in_valid,
        output s, cout, ovf, ovf_sticky, zero, out_valid, op_cnt
    );
endinterface

// File: rtl/addac_n.sv
// Parametrised add/subtract accumulator with signed-overflow detection, sticky overflow,
// accepted-op counter and a one-cycle result-valid strobe.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : addac_n_if.slave (a, sel0, sel1, in_valid in; s, cout, ovf, ovf_sticky, zero,
//            out_valid, op_cnt out)
// Ops ({sel1,sel0}): 00 ADD, 01 SUB, 10 LOAD, 11 CLEAR.
// Build option: define ADDAC_SATURATE_EN to clamp s on ADD/SUB signed overflow instead of
// wrapping.
module addac_n #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    addac_n_if.slave   bus
);
    typedef enum logic {StIdle, StUpd} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       op;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             add_ovf;
    logic [WIDTH-1:0] arith_res;

    assign op = {bus.sel1, bus.sel0};

    // sel0 doubles as invert-operand and carry-in, so SUB is s + ~a + 1.
    assign b              = bus.sel0 ? ~bus.a : bus.a;
    assign {carry, sum}   = {1'b0, s_q} + {1'b0, b} + {{WIDTH{1'b0}}, bus.sel0};
    assign add_ovf        = (s_q[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != s_q[WIDTH-1]);

`ifdef ADDAC_SATURATE_EN
    // Overflow only occurs when both inputs share a sign, so s's sign gives the direction.
    always_comb begin
        arith_res = sum;
        if (add_ovf) begin
            arith_res = s_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign arith_res = sum;
`endif

    // Control FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Control FSM: next state
    always_comb begin
        state_d = bus.in_valid ? StUpd : StIdle;
    end

    // Control FSM: outputs
    always_comb begin
        bus.out_valid = (state_q == StUpd);
    end

    // Datapath next state
    always_comb begin
        s_d      = s_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (bus.in_valid) begin
            unique case (op)
                2'b00, 2'b01: begin
                    s_d      = arith_res;
                    cout_d   = carry;
                    ovf_d    = add_ovf;
                    sticky_d = sticky_q | add_ovf;
                    cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                2'b10: begin
                    s_d    = bus.a;
                    cout_d = 1'b0;
                    ovf_d  = 1'b0;
                    cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                2'b11: begin
                    s_d      = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    sticky_d = 1'b0;
                    cnt_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q      <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s_q      <= s_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.s          = s_q;
    assign bus.cout       = cout_q;
    assign bus.ovf        = ovf_q;
    assign bus.ovf_sticky = sticky_q;
    assign bus.zero       = (s_q == '0);
    assign bus.op_cnt     = cnt_q;
endmodule

// File: tb/tb_addac_n.sv
// Self-checking bench for addac_n (WIDTH=8, CNT_W=8): directed scenarios followed by random
// operations, all compared against an integer-arithmetic reference model.
module tb_addac_n;
    localparam int unsigned W = 8;
    localparam int unsigned C = 8;
    localparam int SMAX = 127;
    localparam int SMIN = -128;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int m_s, m_cout, m_ovf, m_sticky, m_cnt, m_ov;

    addac_n_if #(.WIDTH(W), .CNT_W(C)) bus ();

    addac_n #(.WIDTH(W), .CNT_W(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s = 0; m_cout = 0; m_ovf = 0; m_sticky = 0; m_cnt = 0; m_ov = 0;
    endtask

    function automatic int to_signed(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    task automatic model_op(input logic [1:0] op, input logic [7:0] av);
        int r;
        int u;
        case (op)
            2'd0, 2'd1: begin
                r = (op == 2'd0) ? to_signed(m_s) + to_signed(int'(av))
                                 : to_signed(m_s) - to_signed(int'(av));
                u = (op == 2'd0) ? m_s + int'(av) : m_s + (255 - int'(av)) + 1;
                m_cout = (u >= 256) ? 1 : 0;
                m_ovf  = (r > SMAX || r < SMIN) ? 1 : 0;
                if (m_ovf == 1) m_sticky = 1;
`ifdef ADDAC_SATURATE_EN
                if (r > SMAX) r = SMAX;
                else if (r < SMIN) r = SMIN;
`endif
                m_s = r & 255;
                m_cnt = (m_cnt + 1) % 256;
            end
            2'd2: begin
                m_s = int'(av); m_cout = 0; m_ovf = 0;
                m_cnt = (m_cnt + 1) % 256;
            end
            default: begin
                m_s = 0; m_cout = 0; m_ovf = 0; m_sticky = 0; m_cnt = 0;
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".s"},          32'(bus.s),          32'(m_s));
        chk({tag, ".cout"},       32'(bus.cout),       32'(m_cout));
        chk({tag, ".ovf"},        32'(bus.ovf),        32'(m_ovf));
        chk({tag, ".ovf_sticky"}, 32'(bus.ovf_sticky), 32'(m_sticky));
        chk({tag, ".zero"},       32'(bus.zero),       32'((m_s == 0) ? 1 : 0));
        chk({tag, ".out_valid"},  32'(bus.out_valid),  32'(m_ov));
        chk({tag, ".op_cnt"},     32'(bus.op_cnt),     32'(m_cnt));
    endtask

    // One cycle: drive on the falling edge, check 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [1:0] op, input logic [7:0] av,
                        input string tag);
        @(negedge clk);
        bus.in_valid = v;
        bus.sel1     = op[1];
        bus.sel0     = op[0];
        bus.a        = av;
        @(posedge clk);
        #1;
        if (v) model_op(op, av);
        m_ov = v ? 1 : 0;
        check_all(tag);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.sel0     = 1'b0;
        bus.sel1     = 1'b0;
        bus.a        = '0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of an ADD
        step(1'b1, 2'd2, 8'h33, "pre_rst_load");
        @(negedge clk);
        bus.in_valid = 1'b1; bus.sel1 = 1'b0; bus.sel0 = 1'b0; bus.a = 8'h11;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst.s_const", 32'(bus.s), 32'h0);
        @(posedge clk);
        #1;
        check_all("rst_held");
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;

        // Positive overflow
        step(1'b1, 2'd2, 8'h7F, "ld7f");
        step(1'b1, 2'd0, 8'h01, "add_ovf");
`ifdef ADDAC_SATURATE_EN
        chk("add_ovf.s_const", 32'(bus.s), 32'h7F);
`else
        chk("add_ovf.s_const", 32'(bus.s), 32'h80);
`endif
        chk("add_ovf.ovf_const", 32'(bus.ovf), 32'h1);
        chk("add_ovf.sticky_const", 32'(bus.ovf_sticky), 32'h1);

        // Subtract with borrow, then without
        step(1'b1, 2'd2, 8'h05, "ld05");
        step(1'b1, 2'd1, 8'h07, "sub07");
        chk("sub07.s_const", 32'(bus.s), 32'hFE);
        chk("sub07.cout_const", 32'(bus.cout), 32'h0);
        step(1'b1, 2'd1, 8'hFE, "subfe");
        chk("subfe.s_const", 32'(bus.s), 32'h00);
        chk("subfe.cout_const", 32'(bus.cout), 32'h1);

        // Unsigned carry out without signed overflow
        step(1'b1, 2'd2, 8'hFF, "ldff");
        step(1'b1, 2'd0, 8'h01, "add_carry");
        chk("add_carry.cout_const", 32'(bus.cout), 32'h1);
        chk("add_carry.zero_const", 32'(bus.zero), 32'h1);
        chk("add_carry.sticky_const", 32'(bus.ovf_sticky), 32'h1);

        // Idle cycles with noise on select/operand
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 2'($urandom_range(0, 3)), 8'($urandom), "idle");
        end

        // 256 back-to-back increments from CLEAR
        step(1'b1, 2'd3, 8'h00, "clear");
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 2'd0, 8'h01, "inc");
        end
        chk("wrap.op_cnt_const", 32'(bus.op_cnt), 32'h0);
        chk("wrap.sticky_const", 32'(bus.ovf_sticky), 32'h1);
`ifdef ADDAC_SATURATE_EN
        chk("wrap.s_const", 32'(bus.s), 32'h7F);
`else
        chk("wrap.s_const", 32'(bus.s), 32'h00);
`endif
        step(1'b1, 2'd3, 8'h5A, "clear2");
        chk("clear2.sticky_const", 32'(bus.ovf_sticky), 32'h0);
        step(1'b0, 2'd0, 8'h00, "gap");

        // Random operations
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [1:0] op;
            r = int'($urandom_range(0, 9));
            if (r == 0) op = 2'd3;
            else if (r <= 2) op = 2'd2;
            else op = 2'($urandom_range(0, 1));
            step(($urandom_range(0, 3) != 0), op, 8'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
